// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU issue stage.
// Holds the opcode encodings, the default operand width, the command payload
// layout and the result-slot state encoding.
package alu_pkg;

    localparam int unsigned W     = 4;
    localparam int unsigned OPC_W = 2;

    localparam logic [OPC_W-1:0] OP_ADD   = 2'd0;
    localparam logic [OPC_W-1:0] OP_SUB   = 2'd1;
    localparam logic [OPC_W-1:0] OP_PASSA = 2'd2;
    localparam logic [OPC_W-1:0] OP_PASSB = 2'd3;

    // One ALU command as buffered in the FIFO
    typedef struct packed {
        logic [W-1:0]     a;
        logic [W-1:0]     b;
        logic [OPC_W-1:0] opcode;
    } cmd_t;

    // Occupancy of the single-entry result register
    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo: small synchronous FIFO holding ALU commands.
// Ports:
//   clock, reset     rising-edge clock, asynchronous active-high reset
//   push, push_data  write one entry (ignored when full)
//   pop              drop the head entry (ignored when empty)
//   head             current head entry (undefined when count == 0)
//   count            occupancy, 0..DEPTH
// Pointers and count are reset; the storage array is not.
module cmd_fifo #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 10
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push_ok_c;
    logic              pop_ok_c;

    // Local guards keep the pointers consistent even if a caller misbehaves
    assign push_ok_c = push && (count != CNT_W'(DEPTH));
    assign pop_ok_c  = pop && (count != CNT_W'(0));

    // Pointers wrap naturally at DEPTH; count disambiguates full from empty
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok_c) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok_c)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok_c, pop_ok_c})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array
    always_ff @(posedge clock) begin
        if (push_ok_c) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: issue stage in front of a purely combinational ALU.
// Buffers commands in cmd_fifo, presents the head command to the ALU and
// captures the ALU result into a single registered output slot.
// Ports:
//   clock, reset                 rising-edge clock, async active-high reset
//   io_in_valid/ready/bits_*     command producer handshake (a, b, opcode)
//   io_alu_a/b/opcode            head command to the ALU (0 when FIFO empty)
//   io_alu_out                   ALU result, same cycle
//   io_out_valid/ready/bits      result consumer handshake
//   io_out_opcode                opcode that produced io_out_bits
//   io_count                     FIFO occupancy
module alu_op_sequencer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    io_in_valid,
    output logic                    io_in_ready,
    input  logic [W-1:0]            io_in_bits_a,
    input  logic [W-1:0]            io_in_bits_b,
    input  logic [1:0]              io_in_bits_opcode,
    output logic [W-1:0]            io_alu_a,
    output logic [W-1:0]            io_alu_b,
    output logic [1:0]              io_alu_opcode,
    input  logic [W-1:0]            io_alu_out,
    output logic                    io_out_valid,
    input  logic                    io_out_ready,
    output logic [W-1:0]            io_out_bits,
    output logic [1:0]              io_out_opcode,
    output logic [$clog2(DEPTH):0]  io_count
);

    import alu_pkg::*;

    localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
    localparam int unsigned ENTRY_W = 2 * W + OPC_W;

    logic [ENTRY_W-1:0] push_data_c;
    logic [ENTRY_W-1:0] head;
    logic [ENTRY_W-1:0] head_gated_c;
    logic [CNT_W-1:0]   count;
    logic               nonempty_c;
    logic               push_c;
    logic               issue_c;
    slot_state_t        state_q;
    slot_state_t        state_d;

    // Handshake qualifiers; ready and valid come only from registered state
    assign nonempty_c   = (count != CNT_W'(0));
    assign io_in_ready  = (count < CNT_W'(DEPTH));
    assign push_c       = io_in_valid && io_in_ready;
    assign io_out_valid = (state_q == SLOT_FULL);
    assign issue_c      = nonempty_c && (!io_out_valid || io_out_ready);
    assign io_count     = count;

    assign push_data_c = {io_in_bits_a, io_in_bits_b, io_in_bits_opcode};

    cmd_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (ENTRY_W)
    ) u_cmd_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push_c),
        .push_data (push_data_c),
        .pop       (issue_c),
        .head      (head),
        .count     (count)
    );

    // Unwritten storage must never reach the ALU, so an empty FIFO drives zeros
    assign head_gated_c  = nonempty_c ? head : '0;
    assign io_alu_a      = head_gated_c[2*W+OPC_W-1 : W+OPC_W];
    assign io_alu_b      = head_gated_c[W+OPC_W-1 : OPC_W];
    assign io_alu_opcode = head_gated_c[OPC_W-1:0];

    // Result-slot state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= SLOT_EMPTY;
        else       state_q <= state_d;
    end

    // Result-slot next state: issue fills it, a drain without issue empties it
    always_comb begin
        state_d = state_q;
        case (state_q)
            SLOT_EMPTY: if (issue_c) state_d = SLOT_FULL;
            SLOT_FULL:  if (io_out_ready && !issue_c) state_d = SLOT_EMPTY;
            default:    state_d = SLOT_EMPTY;
        endcase
    end

    // Result payload; holds its value across drains and stalls
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            io_out_bits   <= '0;
            io_out_opcode <= '0;
        end else if (issue_c) begin
            io_out_bits   <= io_alu_out;
            io_out_opcode <= io_alu_opcode;
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;

    localparam int DEPTH = 4;
    localparam int W     = 4;

    typedef struct {
        int res;
        int op;
    } exp_t;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            io_in_valid = 1'b0;
    logic            io_in_ready;
    logic [W-1:0]    io_in_bits_a = '0;
    logic [W-1:0]    io_in_bits_b = '0;
    logic [1:0]      io_in_bits_opcode = '0;
    logic [W-1:0]    io_alu_a;
    logic [W-1:0]    io_alu_b;
    logic [1:0]      io_alu_opcode;
    logic [W-1:0]    io_alu_out;
    logic            io_out_valid;
    logic            io_out_ready = 1'b0;
    logic [W-1:0]    io_out_bits;
    logic [1:0]      io_out_opcode;
    logic [2:0]      io_count;

    int   n_cmp  = 0;
    int   n_fail = 0;
    int   n_pops = 0;
    int   max_cnt = 0;
    bit   streaming = 0;
    bit   prev_hold = 0;
    int   prev_bits = 0;
    int   prev_op = 0;
    exp_t exp_q[$];

    always #5 clock = ~clock;

    alu_op_sequencer #(.DEPTH(DEPTH), .W(W)) dut (
        .clock             (clock),
        .reset             (reset),
        .io_in_valid       (io_in_valid),
        .io_in_ready       (io_in_ready),
        .io_in_bits_a      (io_in_bits_a),
        .io_in_bits_b      (io_in_bits_b),
        .io_in_bits_opcode (io_in_bits_opcode),
        .io_alu_a          (io_alu_a),
        .io_alu_b          (io_alu_b),
        .io_alu_opcode     (io_alu_opcode),
        .io_alu_out        (io_alu_out),
        .io_out_valid      (io_out_valid),
        .io_out_ready      (io_out_ready),
        .io_out_bits       (io_out_bits),
        .io_out_opcode     (io_out_opcode),
        .io_count          (io_count)
    );

    // Reference ALU behaviour in plain modular arithmetic
    function automatic int ref_alu(input int a, input int b, input int op);
        case (op)
            0:       return (a + b) % 16;
            1:       return (a - b + 16) % 16;
            2:       return a;
            default: return b;
        endcase
    endfunction

    // Stand-in for the external combinational ALU
    always_comb io_alu_out = W'(ref_alu(int'(io_alu_a), int'(io_alu_b), int'(io_alu_opcode)));

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard push: every accepted command yields one expected result
    always @(negedge clock) begin
        if (!reset && io_in_valid && io_in_ready) begin
            exp_t e;
            e.res = ref_alu(int'(io_in_bits_a), int'(io_in_bits_b), int'(io_in_bits_opcode));
            e.op  = int'(io_in_bits_opcode);
            exp_q.push_back(e);
        end
    end

    // Monitor: compare each consumed result and check stability under stall
    always @(negedge clock) begin
        if (!reset) begin
            if (prev_hold) begin
                chk("stall_valid", int'(io_out_valid), 1);
                chk("stall_bits", int'(io_out_bits), prev_bits);
                chk("stall_opcode", int'(io_out_opcode), prev_op);
            end
            if (io_out_valid && io_out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("stray_result", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("sb_bits", int'(io_out_bits), e.res);
                    chk("sb_opcode", int'(io_out_opcode), e.op);
                end
                n_pops++;
            end
            prev_hold = io_out_valid && !io_out_ready;
            prev_bits = int'(io_out_bits);
            prev_op   = int'(io_out_opcode);
            if (streaming && int'(io_count) > max_cnt) max_cnt = int'(io_count);
        end else begin
            prev_hold = 0;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input int a, input int b, input int op);
        int i;
        io_in_valid       = 1'b1;
        io_in_bits_a      = W'(a);
        io_in_bits_b      = W'(b);
        io_in_bits_opcode = 2'(op);
        i = 0;
        while (!io_in_ready && i < 50) begin
            tick();
            i++;
        end
        if (!io_in_ready) chk("send_timeout", 0, 1);
        else tick();
        io_in_valid = 1'b0;
    endtask

    task automatic drain();
        int i;
        io_out_ready = 1'b1;
        i = 0;
        while ((exp_q.size() != 0 || io_out_valid) && i < 200) begin
            tick();
            i++;
        end
        if (exp_q.size() != 0 || io_out_valid) chk("drain_timeout", 0, 1);
        io_out_ready = 1'b0;
    endtask

    // Single command through an idle pipeline, with exact latency checks
    task automatic one_shot(input int a, input int b, input int op, input int exp);
        io_out_ready = 1'b0;
        send(a, b, op);
        chk("lat_not_yet_valid", int'(io_out_valid), 0);
        chk("head_alu_a", int'(io_alu_a), a);
        chk("head_alu_opcode", int'(io_alu_opcode), op);
        tick();
        chk("lat_valid", int'(io_out_valid), 1);
        chk("lat_bits", int'(io_out_bits), exp);
        chk("lat_opcode", int'(io_out_opcode), op);
        chk("alu_idle_zero", int'(io_alu_a) + int'(io_alu_b) + int'(io_alu_opcode), 0);
        io_out_ready = 1'b1;
        tick();
        io_out_ready = 1'b0;
        chk("drain_clears_valid", int'(io_out_valid), 0);
        chk("bits_held_after_drain", int'(io_out_bits), exp);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_out_valid"}, int'(io_out_valid), 0);
        chk({tag, "_out_bits"}, int'(io_out_bits), 0);
        chk({tag, "_out_opcode"}, int'(io_out_opcode), 0);
        chk({tag, "_count"}, int'(io_count), 0);
        chk({tag, "_in_ready"}, int'(io_in_ready), 1);
        chk({tag, "_alu_a"}, int'(io_alu_a), 0);
        chk({tag, "_alu_b"}, int'(io_alu_b), 0);
        chk({tag, "_alu_opcode"}, int'(io_alu_opcode), 0);
    endtask

    initial begin
        int rec_bits;
        int pops0;

        // Reset state
        #2 reset = 1'b1;
        #1 check_reset_values("rst");
        tick();
        reset = 1'b0;
        tick();

        // Scenario 1: single add
        one_shot(3, 5, 0, 8);

        // Wrap arithmetic
        one_shot(2, 5, 1, 13);
        one_shot(15, 1, 0, 0);
        one_shot(9, 4, 2, 9);
        one_shot(7, 6, 3, 6);

        // Back-pressure: five commands against a stalled consumer
        io_out_ready = 1'b0;
        for (int k = 0; k < 5; k++) send($urandom_range(15), $urandom_range(15), $urandom_range(3));
        chk("bp_count_full", int'(io_count), 4);
        chk("bp_in_ready_low", int'(io_in_ready), 0);
        chk("bp_out_valid", int'(io_out_valid), 1);
        rec_bits = int'(io_out_bits);
        tick(); tick(); tick();
        chk("bp_bits_stable", int'(io_out_bits), rec_bits);
        chk("bp_count_stable", int'(io_count), 4);
        io_out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("bp_one_per_cycle", int'(io_out_valid), 1);
            tick();
        end
        chk("bp_done_valid", int'(io_out_valid), 0);
        chk("bp_done_count", int'(io_count), 0);
        io_out_ready = 1'b0;

        // Full FIFO with a pop in the same cycle: enqueue refused
        for (int k = 0; k < 5; k++) send($urandom_range(15), $urandom_range(15), $urandom_range(3));
        io_in_valid       = 1'b1;
        io_in_bits_a      = W'(1);
        io_in_bits_b      = W'(1);
        io_in_bits_opcode = 2'd0;
        io_out_ready      = 1'b1;
        chk("full_in_ready_low", int'(io_in_ready), 0);
        tick();
        io_in_valid  = 1'b0;
        io_out_ready = 1'b0;
        chk("full_pop_in_ready", int'(io_in_ready), 1);
        chk("full_pop_count", int'(io_count), DEPTH - 1);
        drain();

        // Streaming: valid and ready held high for 20 commands
        pops0        = n_pops;
        max_cnt      = 0;
        streaming    = 1;
        io_out_ready = 1'b1;
        io_in_valid  = 1'b1;
        for (int k = 0; k < 20; k++) begin
            io_in_bits_a      = W'($urandom_range(15));
            io_in_bits_b      = W'($urandom_range(15));
            io_in_bits_opcode = 2'($urandom_range(3));
            chk("stream_in_ready", int'(io_in_ready), 1);
            tick();
        end
        io_in_valid = 1'b0;
        tick();
        tick();
        streaming = 0;
        chk("stream_result_count", n_pops - pops0, 20);
        chk("stream_max_count", max_cnt, 1);
        io_out_ready = 1'b0;
        drain();

        // Random traffic on both handshakes
        for (int k = 0; k < 300; k++) begin
            io_in_valid       = 1'($urandom_range(1));
            io_in_bits_a      = W'($urandom_range(15));
            io_in_bits_b      = W'($urandom_range(15));
            io_in_bits_opcode = 2'($urandom_range(3));
            io_out_ready      = 1'($urandom_range(1));
            tick();
        end
        io_in_valid = 1'b0;
        drain();

        // Reset mid-stream with three queued and one held
        io_out_ready = 1'b0;
        for (int k = 0; k < 4; k++) send($urandom_range(15), $urandom_range(15), $urandom_range(3));
        chk("pre_rst_count", int'(io_count), 3);
        chk("pre_rst_valid", int'(io_out_valid), 1);
        reset = 1'b1;
        #1 check_reset_values("midrst");
        exp_q.delete();
        tick();
        reset = 1'b0;
        io_out_ready = 1'b1;
        tick(); tick(); tick();
        chk("post_rst_no_stale", int'(io_out_valid), 0);
        io_out_ready = 1'b0;
        one_shot(3, 5, 0, 8);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Upstream issue stage for the 4-bit combinational ALU (`behavioral_AND8`). It buffers ALU commands (operand A, operand B, opcode) from a valid/ready producer in a small FIFO. It presents the head command to the ALU's combinational inputs and captures the ALU result in an output register with its own valid/ready handshake. The ALU itself stays purely combinational; all sequencing, back-pressure and buffering live here.

## Interface
- `DEPTH`, default 4: command FIFO entries; power of two, at least 2.
- `W`, default 4: operand/result width; must match the ALU.

Ports:
- `clock`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high.
- `io_in_valid`  in  1  producer has a command.
- `io_in_ready`  out  1  FIFO can accept.
- `io_in_bits_a`  in  W  operand A.
- `io_in_bits_b`  in  W  operand B.
- `io_in_bits_opcode`  in  2  ALU opcode.
- `io_alu_a`  out  W  to ALU `io_a`.
- `io_alu_b`  out  W  to ALU `io_b`.
- `io_alu_opcode`  out  2  to ALU `io_opcode`.
- `io_alu_out`  in  W  from ALU `io_out`.
- `io_out_valid`  out  1  result register holds a result.
- `io_out_ready`  in  1  consumer accepts the result.
- `io_out_bits`  out  W  captured result.
- `io_out_opcode`  out  2  opcode that produced the result.
- `io_count`  out  clog2(DEPTH)+1  FIFO occupancy.

## Operation
- ALU contract, all results mod 2^W:
  - 00: A+B
  - 01: A−B
  - 10: A
  - 11: B
- Enqueue fires when `io_in_valid && io_in_ready`.
  - `io_in_ready = (count < DEPTH)`, registered state only.
  - No bypass: a full FIFO refuses the command even if a pop occurs in the same cycle.
- `io_alu_a/b/opcode` are driven combinationally from the FIFO head entry.
  - When the FIFO is empty they drive 0 (opcode 00).
- Issue fires when the FIFO is non-empty and the result slot is free or draining this cycle: `count != 0 && (!io_out_valid || io_out_ready)`.
- On issue:
  - the head is popped;
  - `io_out_bits <= io_alu_out`;
  - `io_out_opcode <= head opcode`;
  - `io_out_valid <= 1`.
- Drain only (`io_out_valid && io_out_ready`, no issue): `io_out_valid <= 0`. `io_out_bits` holds its last value.
- Simultaneous enqueue and pop: occupancy unchanged; both pointers advance.
- Pointers are log2(DEPTH) bits and wrap naturally. `count` is tracked separately and distinguishes full from empty.
- Result-slot states:
  - EMPTY → FULL on issue;
  - FULL → FULL on drain+issue;
  - FULL → EMPTY on drain without issue.
- Result outputs are stable while `io_out_valid && !io_out_ready`.

## Timing
- Reset values, applied asynchronously and immediately on `reset` high:
  - `io_out_valid = 0`, `io_out_bits = 0`, `io_out_opcode = 0`;
  - `count = 0`, hence `io_in_ready = 1` and `io_count = 0`;
  - `io_alu_* = 0`;
  - pointers 0.
- Reset mid-operation discards all queued and held results; no partial state survives.
- Latency, empty pipeline: command accepted at edge t → head visible after t → issued and captured at edge t+1 → `io_out_valid` high in cycle t+1..t+2. Minimum two edges from acceptance to visibility.
- Throughput: one result per cycle while `io_out_ready` is held high and the FIFO is non-empty.
- The ALU path (head mux → ALU → result register) is one combinational cycle. No registers are placed between `io_alu_*` and `io_alu_out`.
- `io_in_ready` and `io_out_valid` depend only on registered state. There are no combinational ready/valid loops.

## Structure
- Shared package `alu_pkg`:
  - opcode constants `OP_ADD=0`, `OP_SUB=1`, `OP_PASSA=2`, `OP_PASSB=3`;
  - command struct `{a, b, opcode}`;
  - width `W`.
- Sub-module `cmd_fifo`:
  - parameterised DEPTH and entry width;
  - push/pop/count/head;
  - async active-high reset on pointers and count; storage is not reset.
- Top level holds the issue logic and the result register, and connects externally to the ALU.

## Test plan
- Reset then single command `a=3, b=5, op=00`: `io_out_valid` rises two edges after acceptance with `io_out_bits=8` and `io_out_opcode=0`. A one-cycle `io_out_ready` clears valid.
- Wrap arithmetic, ALU model in bench: `a=2, b=5, op=01` → `13`; `a=15, b=1, op=00` → `0`; `op=10` `a=9` → `9`; `op=11` `b=6` → `6`.
- Back-pressure:
  - hold `io_out_ready=0`, push 5 commands;
  - 4 are accepted into the FIFO after the first has issued to the result slot;
  - `io_in_ready=0` when `io_count=4`;
  - result outputs stay stable;
  - release → results emerge in order, one per cycle.
- Full-FIFO with simultaneous pop: at `count=DEPTH` with a pop that cycle, the enqueue is refused. The next cycle `io_in_ready=1` and `count=DEPTH-1`.
- Streaming: `io_in_valid` and `io_out_ready` tied high for 20 commands → 20 results in order, one per cycle after fill, pointers wrap, and `io_count` never exceeds 1.
- Reset asserted mid-stream with 3 queued and 1 held: all outputs return to reset values within the same cycle, no stale result appears after deassertion, and the next command behaves as in scenario 1.
